// File: rtl/fetch_if.sv
// Fetch-stage bundle: ROM port, redirect inputs and the valid/ready link to decode.
interface fetch_if #(
    parameter int ADDR_W = 5
);
    logic              fetch_en;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              if_valid;
    logic              id_ready;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic              fetch_err;

    modport slave (
        input  fetch_en, redirect, redirect_pc, rom_data, id_ready,
        output rom_addr, if_valid, instr, instr_pc, fetch_err
    );

    modport master (
        output fetch_en, redirect, redirect_pc, rom_data, id_ready,
        input  rom_addr, if_valid, instr, instr_pc, fetch_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one ROM read per cycle, skid-buffers decode stalls.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 5
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.slave bus
);
    typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic        rsp_v_q;
    logic [31:0] rsp_pc_q;
    logic        skid_v_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;
    logic        fetch_err_q;

    logic any_v;
    logic run;
    logic stall;
    logic issue;
    logic if_valid;

    assign any_v    = rsp_v_q | skid_v_q;
    assign run      = (state_q == RUN);
    assign stall    = any_v & ~bus.id_ready;
    assign issue    = run & bus.fetch_en & ~stall & ~bus.redirect;
    assign if_valid = any_v & ~bus.redirect & run;

    // The ROM word on rom_data belongs to rsp_pc_q; the skid buffer only wins while it holds a word.
    assign bus.rom_addr  = fetch_pc_q[ADDR_W+1:2];
    assign bus.if_valid  = if_valid;
    assign bus.instr     = if_valid ? (skid_v_q ? skid_instr_q : bus.rom_data) : 32'h0;
    assign bus.instr_pc  = if_valid ? (skid_v_q ? skid_pc_q    : rsp_pc_q)     : 32'h0;
    assign bus.fetch_err = fetch_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            fetch_pc_q   <= RESET_PC;
            rsp_v_q      <= 1'b0;
            rsp_pc_q     <= 32'h0;
            skid_v_q     <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            fetch_err_q  <= 1'b0;
        end else if (state_q == ERR) begin
            rsp_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
        end else if (bus.redirect) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (bus.redirect_pc[1:0] != 2'b00) begin
                state_q     <= ERR;
                fetch_err_q <= 1'b1;
            end else begin
                fetch_pc_q <= bus.redirect_pc;
            end
`else
            fetch_pc_q <= bus.redirect_pc & ~32'h3;
`endif
            rsp_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            rsp_v_q <= issue;
            if (issue) begin
                rsp_pc_q   <= fetch_pc_q;
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            // A stalled ROM word has no second chance on rom_data, so park it.
            if (rsp_v_q && !skid_v_q && !bus.id_ready) begin
                skid_v_q     <= 1'b1;
                skid_instr_q <= bus.rom_data;
                skid_pc_q    <= rsp_pc_q;
            end else if (skid_v_q && bus.id_ready) begin
                skid_v_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences the 32-entry synchronous instruction ROM (1-cycle read latency, address = PC word index). It issues one ROM read per cycle, tracks which PC each returning word belongs to, and delivers instruction/PC pairs to decode over a valid/ready handshake. A one-entry skid buffer absorbs decode back-pressure, and branch/jump redirects flush the wrong-path fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset; must be word aligned.
- `ADDR_W`, default 5: ROM word-address width; ROM depth is 2^ADDR_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `fetch_en` in 1: 1 allows new ROM reads; 0 freezes issue without flushing.
- `redirect` in 1: 1-cycle pulse, load new PC and flush in-flight fetch.
- `redirect_pc` in 32: redirect target.
- `rom_addr` out ADDR_W: ROM address; equals `fetch_pc[ADDR_W+1:2]`.
- `rom_data` in 32: ROM read data for the address presented on the previous cycle.
- `if_valid` out 1: `instr`/`instr_pc` valid to decode.
- `id_ready` in 1: decode accepts this cycle.
- `instr` out 32: instruction word; 0 when `if_valid`=0.
- `instr_pc` out 32: PC of `instr`; 0 when `if_valid`=0.
- `fetch_err` out 1: misaligned-redirect error (see Configuration).

## Operation
- Registers: `fetch_pc` (PC being read), `rsp_v`/`rsp_pc` (ROM word this cycle belongs to `rsp_pc`), `skid_v`/`skid_instr`/`skid_pc`, `state`.
- States: RUN (normal), ERR (only with macro). Reset enters RUN.
- Output select: `skid_v` ? skid registers : (`rom_data`, `rsp_pc`). `if_valid` = (`skid_v` | `rsp_v`) & !`redirect` & state==RUN.
- `stall` = (`skid_v` | `rsp_v`) & !`id_ready`.
- `issue` = state==RUN & `fetch_en` & !`stall` & !`redirect`. On issue: `rsp_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4; `rsp_v`<=`issue` every cycle.
- Back-pressure: if `rsp_v` & !`skid_v` & !`id_ready`, capture `rom_data`/`rsp_pc` into skid. `skid_v` clears when `id_ready` & `skid_v`. `rsp_v` and `skid_v` are never both 1.
- Redirect (highest priority, any state but ERR): `fetch_pc`<=`redirect_pc`, `rsp_v`<=0, `skid_v`<=0; displayed instruction is dropped (`if_valid` masked that cycle).
- `fetch_en`=0: no new issue; held/in-flight word still delivered normally.
- Arithmetic: `fetch_pc` is 32-bit, wraps 0xFFFF_FFFC -> 0; ROM index wraps modulo 2^ADDR_W (PC 0x80 reads word 0 for ADDR_W=5).

## Timing
- Reset (async assert): `fetch_pc`=RESET_PC, `rom_addr`=RESET_PC[ADDR_W+1:2], `rsp_v`=`skid_v`=0, `if_valid`=0, `instr`=`instr_pc`=0, `fetch_err`=0.
- First instruction: reset released before edge E0 -> issue at E0 -> `if_valid`=1 with RESET_PC word in cycle after E0.
- Steady state with `id_ready`=1: one instruction per cycle, consecutive PCs.
- Redirect asserted in cycle R: target on `rom_addr` in R+1, target instruction valid in R+2.
- Stall: word held stable while `if_valid` & !`id_ready`; after `id_ready` returns, next PC delivered the following cycle with no bubble.
- Redirect while stalled: skid flushed; same R+2 latency.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0]`!=0 enters ERR: `fetch_err`=1, `rsp_v`/`skid_v` cleared, no issue, `if_valid`=0, redirects ignored; exits only via `rst`.
- Undefined: `redirect_pc[1:0]` forced to 00 on load; no ERR state; `fetch_err` tied 0.

## Test plan
- Reset, ROM word i = 0x1000_0000+i, `id_ready`=1: instr_pc 0,4,8,... with matching words, one per cycle from second cycle after reset release.
- Hold `id_ready`=0 for 3 cycles while PC 0x8 displayed: instr/instr_pc stay 0x1000_0002/0x8; then 0xC next cycle after release, no gap, no duplicate.
- Redirect to 0x40 while 0x10 displayed: 0x10 dropped, `if_valid`=0 next cycle, then instr_pc 0x40, 0x44.
- Run past 0x7C with ADDR_W=5: instr_pc 0x80 returns word 0x1000_0000.
- `fetch_en`=0 mid-stream: in-flight word delivered, then `if_valid`=0; re-enable resumes at next PC.
- Redirect to 0x42: with macro `fetch_err`=1 and `if_valid`=0 until `rst`; without macro fetch resumes at 0x40.
